// File: rtl/otp_sched_pkg.sv
// Shared state encodings and width helpers for the OTP bank scheduler.
package otp_sched_pkg;

    localparam int unsigned OTP_RAM_BLOCKS = 8;
    localparam int unsigned OTP_STALL_W    = 16;

    typedef enum logic {
        P_IDLE = 1'b0,
        P_FILL = 1'b1
    } prod_state_e;

    typedef enum logic [1:0] {
        C_IDLE = 2'd0,
        C_WAIT = 2'd1,
        C_HOLD = 2'd2
    } cons_state_e;

    function automatic int unsigned sel_w(input int unsigned blocks);
        return $clog2(blocks);
    endfunction

    // Occupancy needs one extra bit so that "all blocks full" is representable.
    function automatic int unsigned occ_w(input int unsigned blocks);
        return $clog2(blocks) + 1;
    endfunction

endpackage

// File: rtl/otp_sched_ring_ptr.sv
// Modulo-RAM_BLOCKS ring pointer; wraps through power-of-2 truncation, clear wins over inc.
module otp_sched_ring_ptr
    import otp_sched_pkg::*;
#(
    parameter int unsigned RAM_BLOCKS = OTP_RAM_BLOCKS,
    localparam int unsigned SW = sel_w(RAM_BLOCKS)
) (
    input  logic          iclk,
    input  logic          irst_n,
    input  logic          iclr,
    input  logic          iinc,
    output logic [SW-1:0] optr
);

    logic [SW-1:0] ptr_q;

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            ptr_q <= '0;
        end else if (iclr) begin
            ptr_q <= '0;
        end else if (iinc) begin
            ptr_q <= ptr_q + SW'(1);
        end
    end

    assign optr = ptr_q;

endmodule

// File: rtl/otp_bank_sched.sv
// Ring scheduler handing OTP RAM blocks from otp_gen (producer) to sd (consumer).
// Define OTP_SCHED_STATS_EN to enable the saturating consumer stall counter.
module otp_bank_sched
    import otp_sched_pkg::*;
#(
    parameter int unsigned RAM_BLOCKS = OTP_RAM_BLOCKS,
    parameter int unsigned STALL_W    = OTP_STALL_W,
    localparam int unsigned SW        = sel_w(RAM_BLOCKS),
    localparam int unsigned OCC_W     = occ_w(RAM_BLOCKS)
) (
    input  logic               iclk,
    input  logic               irst_n,
    input  logic               iflush,
    output logic               ofill_start,
    output logic [SW-1:0]      ofill_sel,
    input  logic               ifill_done,
    input  logic               iblk_req,
    output logic               oblk_grant,
    output logic [SW-1:0]      oblk_sel,
    input  logic               iblk_release,
    output logic [OCC_W-1:0]   oocc,
    output logic               oempty,
    output logic               ofull,
    output logic               oerr,
    output logic [STALL_W-1:0] ostall_cnt
);

    localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(RAM_BLOCKS);

    prod_state_e      p_state_q, p_state_d;
    cons_state_e      c_state_q, c_state_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             fill_start_q, fill_start_d;
    logic [SW-1:0]    fill_sel_q, fill_sel_d;
    logic             err_q, err_d;
    logic             fill_ok, rel_ok;
    logic [SW-1:0]    wr_ptr, rd_ptr;

    always_comb begin
        p_state_d    = p_state_q;
        c_state_d    = c_state_q;
        occ_d        = occ_q;
        fill_start_d = 1'b0;
        fill_sel_d   = fill_sel_q;
        err_d        = err_q;
        fill_ok      = 1'b0;
        rel_ok       = 1'b0;

        if (iflush) begin
            p_state_d  = P_IDLE;
            c_state_d  = C_IDLE;
            occ_d      = '0;
            fill_sel_d = '0;
        end else begin
            fill_ok = ifill_done && (p_state_q == P_FILL);
            rel_ok  = iblk_release && (c_state_q == C_HOLD);
            if (ifill_done && !fill_ok) err_d = 1'b1;
            if (iblk_release && !rel_ok) err_d = 1'b1;
            // Over/underflow events are flagged and dropped rather than corrupting occ.
            if (fill_ok && !rel_ok && (occ_q == OCC_MAX)) begin
                err_d   = 1'b1;
                fill_ok = 1'b0;
            end
            if (rel_ok && !fill_ok && (occ_q == '0)) begin
                err_d  = 1'b1;
                rel_ok = 1'b0;
            end

            case ({fill_ok, rel_ok})
                2'b10:   occ_d = occ_q + OCC_W'(1);
                2'b01:   occ_d = occ_q - OCC_W'(1);
                default: occ_d = occ_q;
            endcase

            case (p_state_q)
                P_IDLE: begin
                    if (occ_q < OCC_MAX) begin
                        p_state_d    = P_FILL;
                        fill_start_d = 1'b1;
                        fill_sel_d   = wr_ptr;
                    end
                end
                P_FILL: if (fill_ok) p_state_d = P_IDLE;
                default: p_state_d = P_IDLE;
            endcase

            unique case (c_state_q)
                C_IDLE: begin
                    if (iblk_req) c_state_d = (occ_q != '0) ? C_HOLD : C_WAIT;
                end
                C_WAIT: begin
                    if (!iblk_req) c_state_d = C_IDLE;
                    else if (occ_q != '0) c_state_d = C_HOLD;
                end
                C_HOLD: if (rel_ok) c_state_d = C_IDLE;
                default: c_state_d = C_IDLE;
            endcase
        end
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            p_state_q    <= P_IDLE;
            c_state_q    <= C_IDLE;
            occ_q        <= '0;
            fill_start_q <= 1'b0;
            fill_sel_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            p_state_q    <= p_state_d;
            c_state_q    <= c_state_d;
            occ_q        <= occ_d;
            fill_start_q <= fill_start_d;
            fill_sel_q   <= fill_sel_d;
            err_q        <= err_d;
        end
    end

    otp_sched_ring_ptr #(
        .RAM_BLOCKS (RAM_BLOCKS)
    ) u_wr_ptr (
        .iclk   (iclk),
        .irst_n (irst_n),
        .iclr   (iflush),
        .iinc   (fill_ok),
        .optr   (wr_ptr)
    );

    otp_sched_ring_ptr #(
        .RAM_BLOCKS (RAM_BLOCKS)
    ) u_rd_ptr (
        .iclk   (iclk),
        .irst_n (irst_n),
        .iclr   (iflush),
        .iinc   (rel_ok),
        .optr   (rd_ptr)
    );

`ifdef OTP_SCHED_STATS_EN
    logic [STALL_W-1:0] stall_q;

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            stall_q <= '0;
        end else if ((c_state_q == C_WAIT) && (stall_q != '1)) begin
            stall_q <= stall_q + STALL_W'(1);
        end
    end

    assign ostall_cnt = stall_q;
`else
    assign ostall_cnt = '0;
`endif

    assign ofill_start = fill_start_q;
    assign ofill_sel   = fill_sel_q;
    assign oblk_grant  = (c_state_q == C_HOLD);
    assign oblk_sel    = rd_ptr;
    assign oocc        = occ_q;
    assign oempty      = (occ_q == '0);
    assign ofull       = (occ_q == OCC_MAX);
    assign oerr        = err_q;

endmodule

// File: tb/tb_otp_bank_sched.sv
// Self-checking bench for otp_bank_sched: randomized producer/consumer timing vs block-count model.
module tb_otp_bank_sched;

    localparam int RB = 8;
    localparam int SW = 3;

    logic          iclk = 1'b0;
    logic          irst_n = 1'b0;
    logic          iflush = 1'b0;
    logic          ifill_done = 1'b0;
    logic          iblk_req = 1'b0;
    logic          iblk_release = 1'b0;
    logic          ofill_start;
    logic [SW-1:0] ofill_sel;
    logic          oblk_grant;
    logic [SW-1:0] oblk_sel;
    logic [SW:0]   oocc;
    logic          oempty;
    logic          ofull;
    logic          oerr;
    logic [15:0]   ostall_cnt;

    int total = 0;
    int bad = 0;
    // Model: block k is filled into slot k mod RB and consumed in the same order.
    int fills = 0;
    int rels = 0;
    int max_occ = 0;
    logic [SW-1:0] start_q[$];

    otp_bank_sched dut (
        .iclk         (iclk),
        .irst_n       (irst_n),
        .iflush       (iflush),
        .ofill_start  (ofill_start),
        .ofill_sel    (ofill_sel),
        .ifill_done   (ifill_done),
        .iblk_req     (iblk_req),
        .oblk_grant   (oblk_grant),
        .oblk_sel     (oblk_sel),
        .iblk_release (iblk_release),
        .oocc         (oocc),
        .oempty       (oempty),
        .ofull        (ofull),
        .oerr         (oerr),
        .ostall_cnt   (ostall_cnt)
    );

    always #5 iclk = ~iclk;

    always @(negedge iclk) begin
        if (ofill_start) start_q.push_back(ofill_sel);
        if (int'(oocc) > max_occ) max_occ = int'(oocc);
    end

    task automatic step();
        @(negedge iclk);
        #1;
    endtask

    task automatic wait_start(output bit ok, output logic [SW-1:0] sel);
        ok = 1'b0;
        sel = '0;
        for (int i = 0; i < 300; i++) begin
            if (start_q.size() > 0) begin
                sel = start_q.pop_front();
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic do_fill(input int dly, output bit ok, output logic [SW-1:0] sel);
        wait_start(ok, sel);
        if (ok) begin
            repeat (dly) step();
            ifill_done = 1'b1;
            step();
            ifill_done = 1'b0;
        end
    endtask

    task automatic do_consume(input int dly, output bit ok, output logic [SW-1:0] sel);
        iblk_req = 1'b1;
        ok = 1'b0;
        sel = '0;
        for (int i = 0; i < 300; i++) begin
            if (oblk_grant) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (ok) begin
            sel = oblk_sel;
            repeat (dly) step();
            iblk_release = 1'b1;
            step();
            iblk_release = 1'b0;
        end
    endtask

    task automatic do_flush();
        iflush = 1'b1;
        step();
        iflush = 1'b0;
        start_q.delete();
        fills = 0;
        rels = 0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge iclk);
        #1;
        total++; if (ofill_start !== 1'b0) begin bad++; $display("FAIL rst_start: got %0d want 0", ofill_start); end
        total++; if (oblk_grant !== 1'b0) begin bad++; $display("FAIL rst_grant: got %0d want 0", oblk_grant); end
        total++; if (oocc !== 4'd0) begin bad++; $display("FAIL rst_occ: got %0d want 0", oocc); end
        total++; if (oempty !== 1'b1 || ofull !== 1'b0) begin bad++; $display("FAIL rst_flags: got empty=%0d full=%0d want 1/0", oempty, ofull); end
        total++; if (oerr !== 1'b0 || ostall_cnt !== 16'd0) begin bad++; $display("FAIL rst_err_stall: got %0d/%0d want 0/0", oerr, ostall_cnt); end
        irst_n = 1'b1;
    endtask

    task automatic test_fill_full();
        bit ok;
        logic [SW-1:0] sel;
        for (int k = 0; k < RB; k++) begin
            do_fill(int'($urandom_range(0, 3)), ok, sel);
            total++;
            if (!ok || sel !== SW'(fills % RB)) begin
                bad++; $display("FAIL fill_sel: got ok=%0d sel=%0d want sel=%0d", ok, sel, fills % RB);
            end
            fills++;
        end
        repeat (20) step();
        total++; if (start_q.size() != 0) begin bad++; $display("FAIL no_ninth_start: got %0d starts want 0", start_q.size()); end
        total++; if (int'(oocc) != fills - rels) begin bad++; $display("FAIL full_occ: got %0d want %0d", oocc, fills - rels); end
        total++; if (ofull !== 1'b1 || oempty !== 1'b0) begin bad++; $display("FAIL full_flags: got full=%0d empty=%0d want 1/0", ofull, oempty); end
    endtask

    task automatic test_full_release();
        bit ok;
        logic [SW-1:0] sel;
        do_consume(int'($urandom_range(0, 2)), ok, sel);
        iblk_req = 1'b0;
        total++;
        if (!ok || sel !== SW'(rels % RB)) begin bad++; $display("FAIL full_rel_sel: got ok=%0d sel=%0d want %0d", ok, sel, rels % RB); end
        rels++;
        do_fill(0, ok, sel);
        total++;
        if (!ok || sel !== SW'(fills % RB)) begin bad++; $display("FAIL refill_sel: got ok=%0d sel=%0d want %0d", ok, sel, fills % RB); end
        fills++;
        repeat (4) step();
        total++; if (int'(oocc) != fills - rels || ofull !== 1'b1) begin bad++; $display("FAIL refill_occ: got %0d full=%0d want %0d", oocc, ofull, fills - rels); end
        total++; if (max_occ > RB) begin bad++; $display("FAIL occ_bound: got %0d want <= %0d", max_occ, RB); end
    endtask

    task automatic test_wait_grant();
        bit ok;
        logic [SW-1:0] sel;
        do_flush();
        iblk_req = 1'b1;
        repeat (5) step();
        total++; if (oblk_grant !== 1'b0 || oocc !== 4'd0) begin bad++; $display("FAIL wait_nogrant: got grant=%0d occ=%0d want 0/0", oblk_grant, oocc); end
        wait_start(ok, sel);
        total++; if (!ok || sel !== SW'(0)) begin bad++; $display("FAIL wait_fill_sel: got ok=%0d sel=%0d want 0", ok, sel); end
        ifill_done = 1'b1;
        step();
        ifill_done = 1'b0;
        fills++;
        total++; if (oblk_grant !== 1'b0 || oocc !== 4'd1) begin bad++; $display("FAIL wait_n1: got grant=%0d occ=%0d want 0/1", oblk_grant, oocc); end
        step();
        total++; if (oblk_grant !== 1'b1 || oblk_sel !== SW'(0)) begin bad++; $display("FAIL wait_n2: got grant=%0d sel=%0d want 1/0", oblk_grant, oblk_sel); end
`ifdef OTP_SCHED_STATS_EN
        total++; if (ostall_cnt == 16'd0) begin bad++; $display("FAIL stall_cnt: got %0d want >0", ostall_cnt); end
`else
        total++; if (ostall_cnt !== 16'd0) begin bad++; $display("FAIL stall_cnt: got %0d want 0", ostall_cnt); end
`endif
        iblk_release = 1'b1;
        step();
        iblk_release = 1'b0;
        iblk_req = 1'b0;
        rels++;
    endtask

    task automatic test_stream();
        do_flush();
        max_occ = 0;
        fork
            begin
                bit ok;
                logic [SW-1:0] sel;
                for (int i = 0; i < 20; i++) begin
                    do_fill(int'($urandom_range(0, 4)), ok, sel);
                    total++;
                    if (!ok || sel !== SW'(fills % RB)) begin bad++; $display("FAIL stream_fill %0d: got ok=%0d sel=%0d want %0d", i, ok, sel, fills % RB); end
                    fills++;
                end
            end
            begin
                bit ok;
                logic [SW-1:0] sel;
                for (int i = 0; i < 20; i++) begin
                    do_consume(int'($urandom_range(0, 6)), ok, sel);
                    total++;
                    if (!ok || sel !== SW'(rels % RB)) begin bad++; $display("FAIL stream_grant %0d: got ok=%0d sel=%0d want %0d", i, ok, sel, rels % RB); end
                    rels++;
                end
            end
        join
        iblk_req = 1'b0;
        repeat (3) step();
        total++; if (int'(oocc) != fills - rels) begin bad++; $display("FAIL stream_occ: got %0d want %0d", oocc, fills - rels); end
        total++; if (oerr !== 1'b0 || max_occ > RB) begin bad++; $display("FAIL stream_err: got err=%0d max_occ=%0d want 0/<=%0d", oerr, max_occ, RB); end
    endtask

    task automatic test_stray_release();
        bit ok;
        logic [SW-1:0] sel;
        do_flush();
        do_fill(0, ok, sel);
        total++; if (!ok || sel !== SW'(0)) begin bad++; $display("FAIL stray_pre_sel: got ok=%0d sel=%0d want 0", ok, sel); end
        fills++;
        repeat (2) step();
        iblk_release = 1'b1;
        step();
        iblk_release = 1'b0;
        step();
        total++; if (oerr !== 1'b1) begin bad++; $display("FAIL stray_err: got %0d want 1", oerr); end
        total++; if (int'(oocc) != fills - rels) begin bad++; $display("FAIL stray_occ: got %0d want %0d", oocc, fills - rels); end
    endtask

    task automatic test_flush_coincident();
        bit ok;
        logic [SW-1:0] sel;
        iblk_req = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (oblk_grant) begin ok = 1'b1; break; end
            step();
        end
        total++; if (!ok || oblk_sel !== SW'(rels % RB)) begin bad++; $display("FAIL flush_pre_grant: got ok=%0d sel=%0d want %0d", ok, oblk_sel, rels % RB); end
        wait_start(ok, sel);
        total++; if (!ok || sel !== SW'(fills % RB)) begin bad++; $display("FAIL flush_pre_fill: got ok=%0d sel=%0d want %0d", ok, sel, fills % RB); end
        iflush = 1'b1;
        ifill_done = 1'b1;
        step();
        iflush = 1'b0;
        ifill_done = 1'b0;
        iblk_req = 1'b0;
        start_q.delete();
        fills = 0;
        rels = 0;
        total++; if (oocc !== 4'd0 || oempty !== 1'b1) begin bad++; $display("FAIL flush_occ: got %0d empty=%0d want 0/1", oocc, oempty); end
        total++; if (oblk_grant !== 1'b0) begin bad++; $display("FAIL flush_grant: got %0d want 0", oblk_grant); end
        total++; if (oerr !== 1'b1) begin bad++; $display("FAIL flush_err_kept: got %0d want 1", oerr); end
        do_fill(int'($urandom_range(0, 3)), ok, sel);
        total++; if (!ok || sel !== SW'(0)) begin bad++; $display("FAIL flush_wr_ptr: got ok=%0d sel=%0d want 0", ok, sel); end
        fills++;
        do_consume(int'($urandom_range(0, 3)), ok, sel);
        iblk_req = 1'b0;
        total++; if (!ok || sel !== SW'(0)) begin bad++; $display("FAIL flush_rd_ptr: got ok=%0d sel=%0d want 0", ok, sel); end
        rels++;
    endtask

    task automatic test_reset_mid_fill();
        bit ok;
        logic [SW-1:0] sel;
        do_fill(0, ok, sel);
        fills++;
        wait_start(ok, sel);
        iblk_req = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (oblk_grant) break;
            step();
        end
        total++; if (oblk_grant !== 1'b1 || ofill_sel !== SW'(fills % RB)) begin bad++; $display("FAIL mid_setup: got grant=%0d fill_sel=%0d want 1/%0d", oblk_grant, ofill_sel, fills % RB); end
        irst_n = 1'b0;
        #1;
        total++; if (ofill_start !== 1'b0 || ofill_sel !== SW'(0)) begin bad++; $display("FAIL async_fill: got start=%0d sel=%0d want 0/0", ofill_start, ofill_sel); end
        total++; if (oblk_grant !== 1'b0 || oblk_sel !== SW'(0)) begin bad++; $display("FAIL async_grant: got grant=%0d sel=%0d want 0/0", oblk_grant, oblk_sel); end
        total++; if (oocc !== 4'd0 || ofull !== 1'b0 || oerr !== 1'b0 || ostall_cnt !== 16'd0) begin bad++; $display("FAIL async_state: got occ=%0d full=%0d err=%0d stall=%0d want 0", oocc, ofull, oerr, ostall_cnt); end
        iblk_req = 1'b0;
        step();
        irst_n = 1'b1;
        start_q.delete();
        fills = 0;
        rels = 0;
        step();
    endtask

    initial begin
        test_reset();
        test_fill_full();
        test_full_release();
        test_wait_grant();
        test_stream();
        test_stray_release();
        test_flush_coincident();
        test_reset_mid_fill();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
